id_ex_operand_stage: RTL and testbench

//  Decode/operand-fetch stage directly upstream of the 2-bit-op ALU (xnor/add/and/sub).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/reg_file.sv | 68 ++++++
 rtl/id_ex_operand_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants for the decode/operand stage and the 2-bit-op
//             ALU it feeds: ALU_op encodings, R-type funct3 values and the
//             bit offsets of the instruction fields used by decode.
//  Ports    : none (package)
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU_op encodings driven to the downstream ALU
  localparam logic [1:0] ALU_OP_XNOR = 2'b00;
  localparam logic [1:0] ALU_OP_ADD  = 2'b01;
  localparam logic [1:0] ALU_OP_AND  = 2'b10;
  localparam logic [1:0] ALU_OP_SUB  = 2'b11;

  // R-type funct3 values understood by this stage
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_XNOR   = 3'b100;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Instruction field positions (LSB of each field)
  localparam int RS2_LSB  = 20;
  localparam int RS1_LSB  = 15;
  localparam int F3_LSB   = 12;
  localparam int RD_LSB   = 7;
  localparam int F7B5_BIT = 30;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : 2**AW x XLEN register file with two asynchronous read ports
//             and one synchronous write port. Entry 0 always reads zero and
//             is never written. Asynchronous reset clears every entry.
//  Ports    : clk, rst            - clock, async active-high reset
//             raddr1/rdata1       - read port 1
//             raddr2/rdata2       - read port 2
//             we, waddr, wdata    - write port (ignored when waddr == 0)
//  Config   : WB_BYPASS_EN - when defined, a read of the address being
//             written this cycle returns wdata (write-through forwarding);
//             otherwise the old contents are returned until the next cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int DEPTH = 2 ** AW;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic            w_wr_en;

  assign w_wr_en = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write so a same-cycle reader sees the new value.
  always_comb begin
    rdata1 = r_mem[raddr1];
    rdata2 = r_mem[raddr2];
    if (w_wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (w_wr_en && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end
`else
  always_comb begin
    rdata1 = r_mem[raddr1];
    rdata2 = r_mem[raddr2];
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end
`endif

endmodule : reg_file
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : Decode/operand-fetch stage ahead of the 2-bit-op ALU
//             (xnor/add/and/sub). Decodes R-type instructions, reads rs1/rs2
//             from the register file and holds the result in one valid/ready
//             pipeline slot that drives the ALU a/b/ALU_op inputs.
//  Ports    : clk, rst                    - clock, async active-high reset
//             in_valid/in_ready/in_instr  - instruction input handshake
//             flush                       - drop held and incoming instr
//             wb_we/wb_rd/wb_data         - register-file writeback
//             out_valid/out_ready         - output slot handshake
//             out_a/out_b/out_alu_op      - operands and op for the ALU
//             out_rd/out_we/out_illegal   - destination, write flag, illegal
//  Config   : WB_BYPASS_EN - same-cycle writeback forwarding into the read
//             ports (see reg_file).
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [1:0]      out_alu_op,
  output logic [AW-1:0]   out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [AW-1:0]   w_rd;
  logic [2:0]      w_funct3;
  logic            w_b30;
  logic            w_unused_bits;

  assign w_rs1    = in_instr[RS1_LSB +: AW];
  assign w_rs2    = in_instr[RS2_LSB +: AW];
  assign w_rd     = in_instr[RD_LSB  +: AW];
  assign w_funct3 = in_instr[F3_LSB  +: 3];
  assign w_b30    = in_instr[F7B5_BIT];
  // Opcode and remaining funct7 bits carry no meaning for this stage.
  assign w_unused_bits = ^{in_instr[31], in_instr[29:25], in_instr[6:0]};

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [1:0] w_alu_op;
  logic       w_illegal;
  logic       w_we;

  always_comb begin
    w_alu_op  = ALU_OP_ADD;
    w_illegal = 1'b0;
    unique case (w_funct3)
      F3_ADDSUB: w_alu_op = w_b30 ? ALU_OP_SUB : ALU_OP_ADD;
      F3_AND:    w_alu_op = ALU_OP_AND;
      F3_XNOR:   w_alu_op = ALU_OP_XNOR;
      default:   w_illegal = 1'b1;
    endcase
  end

  // Writes to x0 are architecturally discarded, so never request them.
  assign w_we = !w_illegal && (w_rd != '0);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  reg_file #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (w_rs1),
    .raddr2 (w_rs2),
    .rdata1 (w_rs1_data),
    .rdata2 (w_rs2_data),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // --------------------------------------------------------------------------
  // Pipeline slot
  // --------------------------------------------------------------------------
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_alu_op;
  logic [AW-1:0]   r_rd;
  logic            r_we;
  logic            r_illegal;
  logic            w_capture;

  assign in_ready  = !r_valid || out_ready;
  // flush takes priority over a capture offered in the same cycle.
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_op  <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_a       <= w_rs1_data;
      r_b       <= w_rs2_data;
      r_alu_op  <= w_alu_op;
      r_rd      <= w_rd;
      r_we      <= w_we;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      // Consumed with nothing new: fields keep their last value.
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_a       = r_a;
  assign out_b       = r_b;
  assign out_alu_op  = r_alu_op;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_illegal = r_illegal;

endmodule : id_ex_operand_stage
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Self-checking bench for id_ex_operand_stage: a behavioural
//             model tracks register contents and the expected slot, a
//             negedge compare process checks every cycle, and directed
//             sequences add hand-computed literal expectations.
//  Config   : honours WB_BYPASS_EN for the same-cycle read expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            flush;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [1:0]      out_alu_op;
  logic [AW-1:0]   out_rd;
  logic            out_we;
  logic            out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_op  (out_alu_op),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  // ---------------------------------------------------------------- model
  logic [XLEN-1:0] m_regs [32];
  logic            m_valid;
  logic [XLEN-1:0] m_a, m_b;
  logic [1:0]      m_op;
  logic [AW-1:0]   m_rd;
  logic            m_we, m_ill;

  function automatic logic [XLEN-1:0] model_read(input int idx);
    if (idx == 0) return '0;
    if (BYPASS && wb_we && wb_rd != 0 && int'(wb_rd) == idx) return wb_data;
    return m_regs[idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_we = 0; m_ill = 0;
    end else begin
      logic can_take;
      can_take = !m_valid || out_ready;
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && can_take) begin
        int f3;
        f3      = int'(in_instr[14:12]);
        m_valid = 1;
        m_a     = model_read(int'(in_instr[19:15]));
        m_b     = model_read(int'(in_instr[24:20]));
        m_rd    = in_instr[11:7];
        m_ill   = !(f3 == 0 || f3 == 4 || f3 == 7);
        if (f3 == 0)      m_op = in_instr[30] ? 2'd3 : 2'd1;
        else if (f3 == 7) m_op = 2'd2;
        else if (f3 == 4) m_op = 2'd0;
        else              m_op = 2'd1;
        m_we    = !m_ill && (m_rd != 0);
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    chk("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_out_a", out_a, m_a);
    chk("cyc_out_b", out_b, m_b);
    chk("cyc_out_alu_op", 32'(out_alu_op), 32'(m_op));
    chk("cyc_out_rd", 32'(out_rd), 32'(m_rd));
    chk("cyc_out_we", 32'(out_we), 32'(m_we));
    chk("cyc_out_illegal", 32'(out_illegal), 32'(m_ill));
  end

  // ---------------------------------------------------------------- stimulus
  function automatic logic [31:0] mk(input bit b30, input int rs2, input int rs1,
                                     input int f3, input int rd);
    logic [31:0] v;
    v        = 32'h0000_0033;
    v[30]    = b30;
    v[24:20] = rs2[4:0];
    v[19:15] = rs1[4:0];
    v[14:12] = f3[2:0];
    v[11:7]  = rd[4:0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    wb_we = 1; wb_rd = rd[AW-1:0]; wb_data = d;
    step();
    wb_we = 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1; in_instr = ins;
    step();
    in_valid = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; flush = 0;
    wb_we = 0; wb_rd = '0; wb_data = '0; out_ready = 1;
    step(); step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_a", out_a, 32'd0);
    rst = 0;
    step();

    // 1: reset mid-stream clears the slot immediately and the register file
    wb(5, 32'h55);
    issue(mk(0, 0, 5, 0, 6));
    chk("t1_pre_a", out_a, 32'h55);
    rst = 1;
    #1;
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_a", out_a, 32'd0);
    chk("t1_async_rd", 32'(out_rd), 32'd0);
    step();
    rst = 0;
    step();
    issue(mk(0, 5, 5, 0, 1));
    chk("t1_x5_cleared", out_a, 32'd0);
    chk("t1_valid", 32'(out_valid), 32'd1);

    // 2: sub x3 = x1 - x2
    wb(1, 32'd7);
    wb(2, 32'd3);
    issue(mk(1, 2, 1, 0, 3));
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_a", out_a, 32'd7);
    chk("t2_b", out_b, 32'd3);
    chk("t2_op", 32'(out_alu_op), 32'd3);
    chk("t2_we", 32'(out_we), 32'd1);
    chk("t2_rd", 32'(out_rd), 32'd3);
    step();

    // 3: backpressure holds the slot
    out_ready = 0;
    issue(mk(0, 1, 2, 7, 4));
    chk("t3_and_op", 32'(out_alu_op), 32'd2);
    in_valid = 1; in_instr = mk(0, 1, 1, 4, 7);
    for (int i = 0; i < 4; i++) begin
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_hold_a", out_a, 32'd3);
      chk("t3_hold_op", 32'(out_alu_op), 32'd2);
      step();
    end
    out_ready = 1;
    #1;
    chk("t3_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 0;
    chk("t3_next_op", 32'(out_alu_op), 32'd0);
    chk("t3_next_a", out_a, 32'd7);
    chk("t3_next_rd", 32'(out_rd), 32'd7);
    step();

    // 4: flush drops incoming and held instructions
    out_ready = 0; flush = 1;
    issue(mk(0, 2, 2, 0, 8));
    flush = 0;
    chk("t4_drop_valid", 32'(out_valid), 32'd0);
    chk("t4_drop_rd", 32'(out_rd), 32'd7);
    issue(mk(0, 2, 2, 0, 8));
    chk("t4_cap_rd", 32'(out_rd), 32'd8);
    flush = 1;
    issue(mk(0, 1, 1, 0, 9));
    flush = 0;
    chk("t4_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_rd", 32'(out_rd), 32'd8);

    // 5: same-cycle writeback vs read, and x0
    out_ready = 1;
    wb_we = 1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
    issue(mk(0, 0, 4, 0, 10));
    wb_we = 0;
    chk("t5_same_cycle_a", out_a, BYPASS ? 32'hDEAD_BEEF : 32'd0);
    chk("t5_b_x0", out_b, 32'd0);
    issue(mk(0, 0, 4, 0, 10));
    chk("t5_next_a", out_a, 32'hDEAD_BEEF);
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'h1234;
    issue(mk(0, 0, 0, 0, 11));
    wb_we = 0;
    chk("t5_x0_same", out_a, 32'd0);
    issue(mk(0, 0, 0, 0, 11));
    chk("t5_x0_after", out_a, 32'd0);

    // 6: illegal funct3, xnor with rd=0
    issue(mk(0, 1, 2, 2, 9));
    chk("t6_illegal", 32'(out_illegal), 32'd1);
    chk("t6_we", 32'(out_we), 32'd0);
    chk("t6_op", 32'(out_alu_op), 32'd1);
    chk("t6_rd", 32'(out_rd), 32'd9);
    issue(mk(0, 1, 2, 4, 0));
    chk("t6_xnor_op", 32'(out_alu_op), 32'd0);
    chk("t6_xnor_legal", 32'(out_illegal), 32'd0);
    chk("t6_rd0_we", 32'(out_we), 32'd0);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_operand_stage
`default_nettype wire
